// File: rtl/classifier_argmax_pkg.sv
// Shared constants, types and helpers for the classifier argmax block.
package classifier_pkg;

  // Width of one activation value coming from a final-layer node.
  localparam int ACT_W = 8;

  // Default confidence threshold: margins below this flag a low-confidence decision.
  localparam logic [ACT_W-1:0] MARGIN_MIN_DEF = 8'd4;

  // Controller states of the argmax scanner.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } argmax_state_t;

  // Class index width; a single class still needs one index bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/classifier_argmax_if.sv
// Bus between the final network layer / system interface and the argmax block.
//
// Handshakes: a transfer happens on a rising clock edge where both valid and
// ready are high. The producer keeps its data stable while valid is high and
// ready is low; ready may depend on state only, never on the partner's valid.
// Input side: act_in/in_valid (producer) against in_ready (argmax block).
// Output side: result fields/out_valid (argmax block) against out_ready.
interface classifier_argmax_if
  import classifier_pkg::*;
#(
  parameter int N_CLASS = 4
);

  localparam int IDX_W = idx_width(N_CLASS);

  logic [ACT_W*N_CLASS-1:0] act_in;
  logic                     in_valid;
  logic                     in_ready;
  logic                     out_valid;
  logic                     out_ready;
  logic [IDX_W-1:0]         class_idx;
  logic [ACT_W-1:0]         max_val;
  logic [ACT_W-1:0]         margin;
  logic                     low_conf;
  argmax_state_t            state;

  // Argmax block side.
  modport slave (
    input  act_in, in_valid, out_ready,
    output in_ready, out_valid, class_idx, max_val, margin, low_conf, state
  );

  // Network / system side.
  modport master (
    output act_in, in_valid, out_ready,
    input  in_ready, out_valid, class_idx, max_val, margin, low_conf, state
  );

endinterface

// File: rtl/classifier_argmax_update.sv
// One scan step: fold activation v (at index cnt) into the running best/second.
module argmax_update
  import classifier_pkg::*;
#(
  parameter int IDX_W = 2
) (
  input  logic [ACT_W-1:0] v,
  input  logic [IDX_W-1:0] cnt,
  input  logic [ACT_W-1:0] best,
  input  logic [ACT_W-1:0] second,
  input  logic [IDX_W-1:0] best_idx,
  output logic [ACT_W-1:0] next_best,
  output logic [ACT_W-1:0] next_second,
  output logic [IDX_W-1:0] next_best_idx
);

  // Strict compares so an equal later value never steals the lead (lowest index wins).
  always_comb begin
    next_best     = best;
    next_second   = second;
    next_best_idx = best_idx;
    if (v > best) begin
      next_second   = best;
      next_best     = v;
      next_best_idx = cnt;
    end else if (v > second) begin
      next_second = v;
    end
  end

endmodule

// File: rtl/classifier_argmax.sv
// Final-stage decision block: captures a vector of class activations, scans it
// one class per cycle for the winner and runner-up, and presents the winning
// index, its activation, the margin and a low-confidence flag.
module classifier_argmax
  import classifier_pkg::*;
#(
  parameter int               N_CLASS    = 4,
  parameter logic [ACT_W-1:0] MARGIN_MIN = MARGIN_MIN_DEF
) (
  input logic               clk,
  input logic               reset,
  classifier_argmax_if.slave bus
);

  localparam int               IDX_W  = idx_width(N_CLASS);
  // Bank is padded to a power of two so the scan counter indexes it exactly.
  localparam int               BANK_D = 1 << IDX_W;
  localparam logic [IDX_W-1:0] LAST   = IDX_W'(N_CLASS - 1);

  argmax_state_t          state;
  logic                   alive;      // low in reset, high from the first edge after it
  logic [IDX_W-1:0]       cnt;
  logic [ACT_W-1:0]       best;
  logic [ACT_W-1:0]       second;
  logic [IDX_W-1:0]       best_idx;

  logic                   out_valid_r;
  logic [IDX_W-1:0]       class_idx_r;
  logic [ACT_W-1:0]       max_val_r;
  logic [ACT_W-1:0]       margin_r;
  logic                   low_conf_r;

  logic [ACT_W-1:0]       bank [BANK_D];
  logic [ACT_W*BANK_D-1:0] act_pad;

  logic                   in_ready;
  logic                   accept;
  logic [ACT_W-1:0]       v;
  logic [ACT_W-1:0]       next_best;
  logic [ACT_W-1:0]       next_second;
  logic [IDX_W-1:0]       next_best_idx;
  logic [ACT_W-1:0]       next_margin;

  // Ready only while idle and out of reset; keeps in_ready low during reset.
  assign in_ready = (state == IDLE) && alive;
  assign accept   = in_ready && bus.in_valid;
  assign act_pad  = (ACT_W*BANK_D)'(bus.act_in);
  assign v        = bank[cnt];

  argmax_update #(
    .IDX_W (IDX_W)
  ) u_update (
    .v             (v),
    .cnt           (cnt),
    .best          (best),
    .second        (second),
    .best_idx      (best_idx),
    .next_best     (next_best),
    .next_second   (next_second),
    .next_best_idx (next_best_idx)
  );

  // second never exceeds best, so this subtraction cannot wrap.
  assign next_margin = next_best - next_second;

  // Capture the whole activation vector only on an accepted input transfer.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < BANK_D; i++) begin
        bank[i] <= act_pad[ACT_W*i +: ACT_W];
      end
    end
  end

  // Controller: IDLE accepts a vector, SCAN folds one class per cycle, DONE holds the result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      alive       <= 1'b0;
      cnt         <= '0;
      best        <= '0;
      second      <= '0;
      best_idx    <= '0;
      out_valid_r <= 1'b0;
      class_idx_r <= '0;
      max_val_r   <= '0;
      margin_r    <= '0;
      low_conf_r  <= 1'b0;
    end else begin
      alive <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            best     <= '0;
            second   <= '0;
            best_idx <= '0;
            cnt      <= '0;
            state    <= SCAN;
          end
        end
        SCAN: begin
          best     <= next_best;
          second   <= next_second;
          best_idx <= next_best_idx;
          cnt      <= cnt + 1'b1;
          if (cnt == LAST) begin
            class_idx_r <= next_best_idx;
            max_val_r   <= next_best;
            margin_r    <= next_margin;
            low_conf_r  <= (next_margin < MARGIN_MIN);
            out_valid_r <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_r;
  assign bus.class_idx = class_idx_r;
  assign bus.max_val   = max_val_r;
  assign bus.margin    = margin_r;
  assign bus.low_conf  = low_conf_r;
  assign bus.state     = state;

endmodule

// File: tb/tb_classifier_argmax.sv
// Bench for classifier_argmax: three instances (4, 1 and 12 classes) driven
// with directed and random vectors, checked against a sort-based model.
module tb_classifier_argmax;
  import classifier_pkg::*;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;
  logic [31:0] exp_q[$];

  classifier_argmax_if #(.N_CLASS(4))  b4  ();
  classifier_argmax_if #(.N_CLASS(1))  b1  ();
  classifier_argmax_if #(.N_CLASS(12)) b12 ();

  classifier_argmax #(.N_CLASS(4),  .MARGIN_MIN(8'd4)) dut4  (.clk(clk), .reset(reset), .bus(b4));
  classifier_argmax #(.N_CLASS(1),  .MARGIN_MIN(8'd4)) dut1  (.clk(clk), .reset(reset), .bus(b1));
  classifier_argmax #(.N_CLASS(12), .MARGIN_MIN(8'd4)) dut12 (.clk(clk), .reset(reset), .bus(b12));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, vectors=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Winner = largest value, first occurrence; runner-up = second entry of a descending sort.
  function automatic logic [31:0] model(input int vals[$]);
    int s[$];
    int mx, sec, idx, mg;
    s = vals;
    s.rsort();
    mx  = s[0];
    sec = (s.size() > 1) ? s[1] : 0;
    idx = 0;
    for (int i = vals.size() - 1; i >= 0; i--) if (vals[i] == mx) idx = i;
    mg = mx - sec;
    return {8'(idx), 8'(mx), 8'(mg), 7'd0, (mg < 4)};
  endfunction

  function automatic int rv();
    case ($urandom_range(0, 3))
      0: return int'($urandom_range(126, 129));
      1: return int'($urandom_range(0, 3));
      default: return int'($urandom_range(0, 255));
    endcase
  endfunction

  // ---------------- DUT access helpers ----------------
  function automatic logic get_ready(input int d);
    case (d)
      0: return b4.in_ready;
      1: return b1.in_ready;
      default: return b12.in_ready;
    endcase
  endfunction

  function automatic logic get_valid(input int d);
    case (d)
      0: return b4.out_valid;
      1: return b1.out_valid;
      default: return b12.out_valid;
    endcase
  endfunction

  function automatic logic [31:0] get_res(input int d);
    case (d)
      0: return {8'(b4.class_idx), b4.max_val, b4.margin, 7'd0, b4.low_conf};
      1: return {8'(b1.class_idx), b1.max_val, b1.margin, 7'd0, b1.low_conf};
      default: return {8'(b12.class_idx), b12.max_val, b12.margin, 7'd0, b12.low_conf};
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_in(input int d, input int vals[$], input logic vld);
    case (d)
      0: begin
        for (int i = 0; i < 4; i++) b4.act_in[8*i +: 8] = 8'(vals[i]);
        b4.in_valid = vld;
      end
      1: begin
        b1.act_in   = 8'(vals[0]);
        b1.in_valid = vld;
      end
      default: begin
        for (int i = 0; i < 12; i++) b12.act_in[8*i +: 8] = 8'(vals[i]);
        b12.in_valid = vld;
      end
    endcase
  endtask

  task automatic set_ordy(input int d, input logic r);
    case (d)
      0: b4.out_ready = r;
      1: b1.out_ready = r;
      default: b12.out_ready = r;
    endcase
  endtask

  // Present a vector and return at the falling edge after the accepting edge.
  task automatic start(input int d, input int vals[$]);
    int n;
    n = 0;
    while (!get_ready(d) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("ready_timeout", 32'(get_ready(d)), 32'd1);
    set_in(d, vals, 1'b1);
    @(negedge clk);
    set_in(d, vals, 1'b0);
  endtask

  // Count edges from acceptance to out_valid, then compare against the scoreboard.
  task automatic wait_result(input int d, input int lat_exp);
    int lat;
    logic [31:0] exp, res;
    lat = 0;
    while (!get_valid(d) && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(lat_exp));
    exp = exp_q.pop_front();
    res = get_res(d);
    check("class_idx", 32'(res[31:24]), 32'(exp[31:24]));
    check("max_val",   32'(res[23:16]), 32'(exp[23:16]));
    check("margin",    32'(res[15:8]),  32'(exp[15:8]));
    check("low_conf",  32'(res[0]),     32'(exp[0]));
  endtask

  task automatic ack(input int d);
    set_ordy(d, 1'b1);
    @(negedge clk);
    check("ready_after_ack", 32'(get_ready(d)), 32'd1);
    check("valid_after_ack", 32'(get_valid(d)), 32'd0);
    set_ordy(d, 1'b0);
  endtask

  task automatic run(input int d, input int vals[$], input int lat_exp);
    exp_q.push_back(model(vals));
    start(d, vals);
    wait_result(d, lat_exp);
    ack(d);
  endtask

  // in_ready and out_valid must never be high together on any instance.
  always @(negedge clk) begin
    if (!reset) begin
      check("excl_4",  32'(b4.in_ready  & b4.out_valid),  32'd0);
      check("excl_1",  32'(b1.in_ready  & b1.out_valid),  32'd0);
      check("excl_12", 32'(b12.in_ready & b12.out_valid), 32'd0);
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int v[$];
    int b[$];
    logic [31:0] hold;
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    b4.act_in = '0;  b4.in_valid = 1'b0;  b4.out_ready = 1'b0;
    b1.act_in = '0;  b1.in_valid = 1'b0;  b1.out_ready = 1'b0;
    b12.act_in = '0; b12.in_valid = 1'b0; b12.out_ready = 1'b0;

    // Reset values.
    #3;
    for (int d = 0; d < 3; d++) begin
      check("rst_ready", 32'(get_ready(d)), 32'd0);
      check("rst_valid", 32'(get_valid(d)), 32'd0);
      check("rst_res",   get_res(d),        32'd0);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("ready_pre_edge", 32'(get_ready(0)), 32'd0);
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) check("ready_first_edge", 32'(get_ready(d)), 32'd1);
    @(negedge clk);

    // Directed vectors for the default size.
    v = '{10, 90, 90, 40};   run(0, v, 4);
    v = '{127, 3, 128, 0};   run(0, v, 4);
    v = '{5, 100, 20, 7};    run(0, v, 4);
    v = '{0, 0, 0, 0};       run(0, v, 4);
    v = '{255, 255, 1, 255}; run(0, v, 4);
    v = '{1, 2, 3, 200};     run(0, v, 4);

    // Random vectors, random acknowledge delay with held outputs.
    for (int t = 0; t < 30; t++) begin
      v = {};
      for (int i = 0; i < 4; i++) v.push_back(rv());
      exp_q.push_back(model(v));
      start(0, v);
      wait_result(0, 4);
      hold = get_res(0);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        check("hold_rand", get_res(0), hold);
      end
      ack(0);
    end

    // Backpressure: results hold, new inputs ignored until the handshake.
    v = '{5, 100, 20, 7};
    b = '{3, 9, 250, 9};
    exp_q.push_back(model(v));
    start(0, v);
    wait_result(0, 4);
    hold = get_res(0);
    for (int i = 0; i < 6; i++) begin
      set_in(0, b, (i % 2) == 0);
      @(negedge clk);
      check("bp_hold",  get_res(0),         hold);
      check("bp_ready", 32'(get_ready(0)),  32'd0);
      check("bp_valid", 32'(get_valid(0)),  32'd1);
    end
    set_in(0, b, 1'b1);
    exp_q.push_back(model(b));
    set_ordy(0, 1'b1);
    @(negedge clk);
    check("bp_ready_after_hs", 32'(get_ready(0)), 32'd1);
    check("bp_valid_after_hs", 32'(get_valid(0)), 32'd0);
    set_ordy(0, 1'b0);
    @(negedge clk);
    check("bp_accepted", 32'(get_ready(0)), 32'd0);
    set_in(0, b, 1'b0);
    wait_result(0, 4);
    ack(0);

    // Reset during SCAN with cnt=2 aborts the vector.
    v = '{200, 1, 2, 3};
    start(0, v);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_res",   get_res(0),        32'd0);
    check("abort_ready", 32'(get_ready(0)), 32'd0);
    check("abort_valid", 32'(get_valid(0)), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_ready_pre", 32'(get_ready(0)), 32'd0);
    @(posedge clk);
    #1;
    check("abort_ready_post", 32'(get_ready(0)), 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("abort_no_valid", 32'(get_valid(0)), 32'd0);
    end
    v = '{4, 8, 15, 16};
    run(0, v, 4);

    // Single-class instance.
    v = '{77};
    run(1, v, 1);
    for (int t = 0; t < 8; t++) begin
      v = {};
      v.push_back(rv());
      run(1, v, 1);
    end

    // Twelve-class instance.
    v = {};
    for (int i = 0; i < 11; i++) v.push_back(int'($urandom_range(0, 249)));
    v.push_back(250);
    run(2, v, 12);
    for (int t = 0; t < 15; t++) begin
      v = {};
      for (int i = 0; i < 12; i++) v.push_back(rv());
      run(2, v, 12);
    end

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/classifier_argmax.md
# classifier_argmax

Final-stage decision block for the ECG classifier network. Consumes the parallel 8-bit activations produced by the last layer's node modules. Scans them sequentially to find the winning class, its activation, and the margin over the runner-up. Presents the result over a valid/ready handshake to the system interface.

## Interface
- `N_CLASS`, default 4: number of final-layer node outputs. Legal range is 1..64.
- `MARGIN_MIN`, default 8'd4: `low_conf` asserts when margin < `MARGIN_MIN`.
- Derived localparam `IDX_W` = max(1, $clog2(`N_CLASS`)).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `act_in`  in  8*`N_CLASS`  activations; class i occupies [8i+7:8i]; each value is unsigned 0..255.
- `in_valid`  in  1  `act_in` holds a complete vector.
- `in_ready`  out  1  block can accept a vector; high only in IDLE.
- `out_valid`  out  1  result registers hold a valid result.
- `out_ready`  in  1  consumer accepts the result.
- `class_idx`  out  `IDX_W`  index of the maximum activation.
- `max_val`  out  8  maximum activation.
- `margin`  out  8  `max_val` minus second-largest activation. Equals `max_val` when `N_CLASS`=1.
- `low_conf`  out  1  (`margin` < `MARGIN_MIN`).

## Operation
- FSM states: IDLE, SCAN, DONE. Reset state is IDLE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`, capture all of `act_in` into a local register bank.
  - Clear best=0, second=0, best_idx=0, scan counter=0.
  - Go to SCAN.
- SCAN: one class per cycle, taking v = bank[cnt]:
  - If v > best: second<=best, best<=v, best_idx<=cnt.
  - Else if v > second: second<=v.
  - cnt increments by 1 each cycle.
  - After processing cnt = `N_CLASS`-1, load the result registers and go to DONE.
- Comparison is strict, so ties resolve to the lowest index. Equal maxima give margin 0.
- Arithmetic:
  - All comparisons are unsigned 8-bit.
  - margin = best - second, which never underflows because second ≤ best.
  - Activation 128 (the rounding overflow of the saturated node output) is a legal value.
- DONE:
  - `out_valid`=1; all result outputs are held stable.
  - On `out_valid`&&`out_ready`, go to IDLE.
- `in_valid` is ignored outside IDLE. The bank is not overwritten during SCAN or DONE.
- Reset: `in_ready`=0, `out_valid`=0, `class_idx`=0, `max_val`=0, `margin`=0, `low_conf`=0, FSM=IDLE.
- Reset asserted mid-SCAN or mid-DONE aborts immediately. The partial result is discarded and never presented.

## Timing
- `in_ready` is decoded combinationally from state. All result outputs and `out_valid` are registered.
- Vector accepted at edge 0 → `out_valid` high after edge `N_CLASS` (4 cycles for the default).
- Handshake completes at edge k → `in_ready` high after edge k. A next vector is accepted at edge k+1 at the earliest.
- Best-case throughput is one vector per `N_CLASS`+2 cycles.
- `in_ready` and `out_valid` are never high together.
- Following reset deassertion, `in_ready` is high from the first clock edge.

## Structure
- Shared package `classifier_pkg`:
  - `ACT_W`=8.
  - FSM state typedef `argmax_state_t` {IDLE, SCAN, DONE}.
  - Default `MARGIN_MIN` constant.
- Sub-module `argmax_update`: combinational step that takes (v, cnt, best, second, best_idx) and returns the updated triple. It is instantiated once in SCAN.
- The top level holds the FSM, bank, counter and result registers.

## Test plan
- Vector [10,90,90,40] → `class_idx`=1, `max_val`=90, `margin`=0, `low_conf`=1. `out_valid` rises exactly 4 cycles after acceptance.
- Vector [127,3,128,0] → `class_idx`=2, `max_val`=128, `margin`=1, `low_conf`=1. Vector [5,100,20,7] → `class_idx`=1, `max_val`=100, `margin`=80, `low_conf`=0.
- All-zero vector → `class_idx`=0, `max_val`=0, `margin`=0, `low_conf`=1.
- Backpressure:
  - Hold `out_ready`=0 for 6 cycles in DONE while toggling `in_valid` with a different `act_in`.
  - Outputs stay constant and `in_ready` stays 0.
  - After `out_ready`=1 handshake, the new vector is accepted on the next cycle and produces its own correct result.
- Assert `reset` for 1 cycle during SCAN (cnt=2):
  - All outputs drop to 0 asynchronously, before the next edge.
  - `out_valid` never pulses for the aborted vector.
  - `in_ready`=1 after the first edge following deassertion.
- Parameter sweep:
  - `N_CLASS`=1, vector [77] → `class_idx`=0, `max_val`=77, `margin`=77, latency 1.
  - `N_CLASS`=12 with the max at index 11 → `class_idx`=11, latency 12.
